// File: rtl/exe_mem_reg.sv
// EX/MEM pipeline register.
// Holds the EX result, store data, destination and memory controls for the memory stage.
// Freezes while a held memory op waits on Ready, and keeps stall statistics for debug.
module exe_mem_reg #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned TIMEOUT = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic             WB_EN_in,
   input  logic             MEM_R_EN_in,
   input  logic             MEM_W_EN_in,
   input  logic [31:0]      ALU_res_in,
   input  logic [31:0]      Val_Rm_in,
   input  logic [3:0]       Dest_in,
   input  logic             mem_ready,
   output logic             valid,
   output logic             WB_EN,
   output logic             MEM_R_EN,
   output logic             MEM_W_EN,
   output logic [31:0]      ALU_res,
   output logic [31:0]      Val_Rm,
   output logic [3:0]       Dest,
   output logic             freeze,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [31:0]      total_stalls,
   output logic             timeout,
   output logic             protocol_err
);

   localparam logic [CNT_W-1:0] CntMax     = '1;
   localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
   // Value of the counter on the edge that makes it reach TIMEOUT
   localparam logic [CNT_W-1:0] TimeoutPre = CNT_W'(TIMEOUT - 1);

   logic             r_valid;
   logic             r_wb_en;
   logic             r_mem_r_en;
   logic             r_mem_w_en;
   logic [31:0]      r_alu_res;
   logic [31:0]      r_val_rm;
   logic [3:0]       r_dest;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [31:0]      r_total_stalls;
   logic             r_timeout;
   logic             r_protocol_err;

   logic             w_mem_op;
   logic             w_freeze;
   logic             w_illegal;

   // Freeze only when a real memory op is held and memory is not ready
   always_comb begin
      w_mem_op  = r_mem_r_en | r_mem_w_en;
      w_freeze  = r_valid & w_mem_op & ~mem_ready;
      w_illegal = valid_in & MEM_R_EN_in & MEM_W_EN_in;
   end

   // Payload and controls: load on advance, hold on freeze; bubbles carry no enables
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid    <= 1'b0;
         r_wb_en    <= 1'b0;
         r_mem_r_en <= 1'b0;
         r_mem_w_en <= 1'b0;
         r_alu_res  <= 32'd0;
         r_val_rm   <= 32'd0;
         r_dest     <= 4'd0;
      end else if (!w_freeze) begin
         r_valid    <= valid_in;
         r_wb_en    <= WB_EN_in & valid_in;
         // Simultaneous read and write: the write wins
         r_mem_r_en <= MEM_R_EN_in & valid_in & ~MEM_W_EN_in;
         r_mem_w_en <= MEM_W_EN_in & valid_in;
         r_alu_res  <= ALU_res_in;
         r_val_rm   <= Val_Rm_in;
         r_dest     <= Dest_in;
      end
   end

   // Stall statistics: saturating run length, wrapping total, sticky watchdog
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt    <= '0;
         r_total_stalls <= 32'd0;
         r_timeout      <= 1'b0;
      end else if (w_freeze) begin
         if (r_stall_cnt != CntMax) begin
            r_stall_cnt <= r_stall_cnt + CntOne;
         end
         r_total_stalls <= r_total_stalls + 32'd1;
         if (r_stall_cnt == TimeoutPre) begin
            r_timeout <= 1'b1;
         end
      end else begin
         r_stall_cnt <= '0;
      end
   end

   // Sticky flag for an illegal read+write captured into the register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_protocol_err <= 1'b0;
      end else if (!w_freeze && w_illegal) begin
         r_protocol_err <= 1'b1;
      end
   end

   // Output mapping
   always_comb begin
      valid        = r_valid;
      WB_EN        = r_wb_en;
      MEM_R_EN     = r_mem_r_en;
      MEM_W_EN     = r_mem_w_en;
      ALU_res      = r_alu_res;
      Val_Rm       = r_val_rm;
      Dest         = r_dest;
      freeze       = w_freeze;
      stall_cnt    = r_stall_cnt;
      total_stalls = r_total_stalls;
      timeout      = r_timeout;
      protocol_err = r_protocol_err;
   end

endmodule

// File: tb/tb_exe_mem_reg.sv
// Directed bench for exe_mem_reg: default instance plus a small-counter instance
// (CNT_W=3, TIMEOUT=4) sharing the same stimulus for the watchdog checks.
module tb_exe_mem_reg;

   logic        clk;
   logic        rst;
   logic        valid_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, mem_ready;
   logic [31:0] ALU_res_in, Val_Rm_in;
   logic [3:0]  Dest_in;

   logic        valid, WB_EN, MEM_R_EN, MEM_W_EN, freeze, timeout, protocol_err;
   logic [31:0] ALU_res, Val_Rm, total_stalls;
   logic [3:0]  Dest;
   logic [7:0]  stall_cnt;

   logic        b_valid, b_WB_EN, b_MEM_R_EN, b_MEM_W_EN, b_freeze, b_timeout, b_protocol_err;
   logic [31:0] b_ALU_res, b_Val_Rm, b_total_stalls;
   logic [3:0]  b_Dest;
   logic [2:0]  b_stall_cnt;

   int n_vec = 0;
   int n_err = 0;

   exe_mem_reg dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .WB_EN_in(WB_EN_in),
      .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .ALU_res_in(ALU_res_in),
      .Val_Rm_in(Val_Rm_in), .Dest_in(Dest_in), .mem_ready(mem_ready),
      .valid(valid), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .ALU_res(ALU_res), .Val_Rm(Val_Rm), .Dest(Dest), .freeze(freeze),
      .stall_cnt(stall_cnt), .total_stalls(total_stalls), .timeout(timeout),
      .protocol_err(protocol_err)
   );

   exe_mem_reg #(.CNT_W(3), .TIMEOUT(4)) dut_b (
      .clk(clk), .rst(rst), .valid_in(valid_in), .WB_EN_in(WB_EN_in),
      .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .ALU_res_in(ALU_res_in),
      .Val_Rm_in(Val_Rm_in), .Dest_in(Dest_in), .mem_ready(mem_ready),
      .valid(b_valid), .WB_EN(b_WB_EN), .MEM_R_EN(b_MEM_R_EN), .MEM_W_EN(b_MEM_W_EN),
      .ALU_res(b_ALU_res), .Val_Rm(b_Val_Rm), .Dest(b_Dest), .freeze(b_freeze),
      .stall_cnt(b_stall_cnt), .total_stalls(b_total_stalls), .timeout(b_timeout),
      .protocol_err(b_protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic wb, input logic r, input logic w,
                        input logic [31:0] alu, input logic [31:0] val, input logic [3:0] d);
      valid_in = v; WB_EN_in = wb; MEM_R_EN_in = r; MEM_W_EN_in = w;
      ALU_res_in = alu; Val_Rm_in = val; Dest_in = d;
   endtask

   task automatic test_reset();
      rst = 1'b0; mem_ready = 1'b0;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'd2);
      step(); step();
      n_vec++;
      if ({valid, WB_EN, MEM_R_EN, MEM_W_EN, freeze, timeout, protocol_err} !== 7'b0) begin
         n_err++; $display("FAIL reset_ctrl: got %b want 0000000",
            {valid, WB_EN, MEM_R_EN, MEM_W_EN, freeze, timeout, protocol_err});
      end
      n_vec++;
      if (ALU_res !== 32'h0 || Val_Rm !== 32'h0 || Dest !== 4'h0 || stall_cnt !== 8'h0
          || total_stalls !== 32'h0) begin
         n_err++; $display("FAIL reset_data: alu=%h val=%h dest=%h cnt=%0d tot=%0d want all 0",
            ALU_res, Val_Rm, Dest, stall_cnt, total_stalls);
      end
      rst = 1'b1;
      step();
      n_vec++;
      if (valid !== 1'b1 || MEM_R_EN !== 1'b1 || ALU_res !== 32'h100 || freeze !== 1'b1) begin
         n_err++; $display("FAIL reset_release: valid=%b r=%b alu=%h frz=%b want 1 1 100 1",
            valid, MEM_R_EN, ALU_res, freeze);
      end
      mem_ready = 1'b1;
      #1;
      n_vec++;
      if (freeze !== 1'b0) begin
         n_err++; $display("FAIL ready_drops_freeze: got %b want 0", freeze);
      end
   endtask

   task automatic test_pass_through();
      mem_ready = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'hDEADBEEF, 4'd5);
      step();
      n_vec++;
      if (valid !== 1'b1 || WB_EN !== 1'b1 || MEM_R_EN !== 1'b0 || MEM_W_EN !== 1'b0
          || ALU_res !== 32'h400 || Val_Rm !== 32'hDEADBEEF || Dest !== 4'd5) begin
         n_err++; $display("FAIL pass_through: v=%b wb=%b r=%b w=%b alu=%h val=%h d=%0d",
            valid, WB_EN, MEM_R_EN, MEM_W_EN, ALU_res, Val_Rm, Dest);
      end
      n_vec++;
      if (stall_cnt !== 8'd0 || freeze !== 1'b0) begin
         n_err++; $display("FAIL pass_stall: cnt=%0d frz=%b want 0 0", stall_cnt, freeze);
      end
   endtask

   task automatic test_load_miss();
      int bad;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h404, 32'h0, 4'd3);
      step();
      mem_ready = 1'b0;
      // Next instruction (a store) waits upstream while the load misses
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h808, 32'h12345678, 4'd7);
      #1;
      n_vec++;
      if (freeze !== 1'b1) begin
         n_err++; $display("FAIL miss_freeze_comb: got %b want 1", freeze);
      end
      bad = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (freeze !== 1'b1 || ALU_res !== 32'h404 || MEM_R_EN !== 1'b1 || Dest !== 4'd3
             || stall_cnt !== 8'(i)) begin
            bad++;
            $display("FAIL miss_hold[%0d]: frz=%b alu=%h r=%b d=%0d cnt=%0d want 1 404 1 3 %0d",
               i, freeze, ALU_res, MEM_R_EN, Dest, stall_cnt, i);
         end
      end
      n_vec++;
      if (bad != 0) n_err++;
      n_vec++;
      if (total_stalls !== 32'd12) begin
         n_err++; $display("FAIL miss_total: got %0d want 12", total_stalls);
      end
      mem_ready = 1'b1;
      step();
      n_vec++;
      if (ALU_res !== 32'h808 || MEM_W_EN !== 1'b1 || MEM_R_EN !== 1'b0 || WB_EN !== 1'b0
          || Val_Rm !== 32'h12345678 || stall_cnt !== 8'd0) begin
         n_err++; $display("FAIL back_to_back: alu=%h w=%b r=%b wb=%b val=%h cnt=%0d",
            ALU_res, MEM_W_EN, MEM_R_EN, WB_EN, Val_Rm, stall_cnt);
      end
   endtask

   task automatic test_bubble();
      mem_ready = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h55, 32'h66, 4'd9);
      step();
      n_vec++;
      if (valid !== 1'b0 || WB_EN !== 1'b0 || MEM_R_EN !== 1'b0 || ALU_res !== 32'h55
          || Dest !== 4'd9) begin
         n_err++; $display("FAIL bubble: v=%b wb=%b r=%b alu=%h d=%0d want 0 0 0 55 9",
            valid, WB_EN, MEM_R_EN, ALU_res, Dest);
      end
      mem_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h66, 32'h0, 4'd1);
      #1;
      n_vec++;
      if (freeze !== 1'b0) begin
         n_err++; $display("FAIL spurious_ready_freeze: got %b want 0", freeze);
      end
      step();
      n_vec++;
      if (valid !== 1'b1 || ALU_res !== 32'h66 || stall_cnt !== 8'd0 || total_stalls !== 32'd12)
      begin
         n_err++; $display("FAIL spurious_ready_adv: v=%b alu=%h cnt=%0d tot=%0d want 1 66 0 12",
            valid, ALU_res, stall_cnt, total_stalls);
      end
   endtask

   task automatic test_timeout();
      int bad;
      mem_ready = 1'b1;
      rst = 1'b0;
      #1;
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h900, 32'hAA, 4'd4);
      step();
      mem_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      bad = 0;
      for (int i = 1; i <= 9; i++) begin
         step();
         if (b_stall_cnt !== 3'((i > 7) ? 7 : i) || b_timeout !== (i >= 4)
             || b_ALU_res !== 32'h900 || stall_cnt !== 8'(i) || timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout[%0d]: bcnt=%0d bto=%b balu=%h cnt=%0d to=%b", i,
               b_stall_cnt, b_timeout, b_ALU_res, stall_cnt, timeout);
         end
      end
      n_vec++;
      if (bad != 0) n_err++;
      mem_ready = 1'b1;
      step();
      n_vec++;
      if (b_timeout !== 1'b1 || b_stall_cnt !== 3'd0 || b_total_stalls !== 32'd9
          || total_stalls !== 32'd9) begin
         n_err++; $display("FAIL timeout_sticky: bto=%b bcnt=%0d btot=%0d tot=%0d want 1 0 9 9",
            b_timeout, b_stall_cnt, b_total_stalls, total_stalls);
      end
   endtask

   task automatic test_illegal();
      mem_ready = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hC00, 32'h77, 4'd6);
      step();
      n_vec++;
      if (MEM_W_EN !== 1'b1 || MEM_R_EN !== 1'b0 || protocol_err !== 1'b1) begin
         n_err++; $display("FAIL illegal: w=%b r=%b perr=%b want 1 0 1",
            MEM_W_EN, MEM_R_EN, protocol_err);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'd2);
      step();
      n_vec++;
      if (protocol_err !== 1'b1 || MEM_W_EN !== 1'b0) begin
         n_err++; $display("FAIL illegal_sticky: perr=%b w=%b want 1 0", protocol_err, MEM_W_EN);
      end
   endtask

   task automatic test_reset_mid_stall();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'd8);
      step();
      mem_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      #1;
      n_vec++;
      if (freeze !== 1'b0 || valid !== 1'b0 || protocol_err !== 1'b0 || stall_cnt !== 8'd0
          || b_timeout !== 1'b0 || ALU_res !== 32'h0) begin
         n_err++; $display("FAIL reset_mid_stall: frz=%b v=%b perr=%b cnt=%0d bto=%b alu=%h",
            freeze, valid, protocol_err, stall_cnt, b_timeout, ALU_res);
      end
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_load_miss();
      test_bubble();
      test_timeout();
      test_illegal();
      test_reset_mid_stall();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/exe_mem_reg.md
Name: exe_mem_reg

Overview:
- EX/MEM pipeline register that feeds the memory stage.
- Captures the EX result, store value, destination and control bits, and presents them to the memory stage.
- Holds its contents while a memory access is waiting on the cache/SRAM path (Ready low).
- Drives the freeze signal to upstream stages, and keeps stall statistics plus a watchdog flag for debugging long SRAM misses.

Parameters:
- CNT_W, 8, width of the consecutive-stall counter.
- TIMEOUT, 200, consecutive-stall count at which the sticky timeout flag sets; must be <= 2^CNT_W - 1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  EX slot holds a real instruction (0 = bubble)
- WB_EN_in  in  1  register write-back enable from EX
- MEM_R_EN_in  in  1  load from EX
- MEM_W_EN_in  in  1  store from EX
- ALU_res_in  in  32  address / ALU result from EX
- Val_Rm_in  in  32  store data from EX
- Dest_in  in  4  destination register from EX
- mem_ready  in  1  Ready from memory stage (0 = access in progress)
- valid  out  1  registered slot valid
- WB_EN  out  1  registered write-back enable
- MEM_R_EN  out  1  registered load enable
- MEM_W_EN  out  1  registered store enable
- ALU_res  out  32  registered ALU result / address
- Val_Rm  out  32  registered store data
- Dest  out  4  registered destination (also used for forwarding)
- freeze  out  1  combinational; stalls PC, IF/ID, ID/EX and this register
- stall_cnt  out  CNT_W  consecutive stall cycles, saturating
- total_stalls  out  32  cumulative stall cycles since reset, wraps mod 2^32
- timeout  out  1  sticky: a stall reached TIMEOUT cycles
- protocol_err  out  1  sticky: illegal read+write captured

Behaviour:
- Reset (rst=0, asynchronous): all outputs and registers go to 0; freeze evaluates to 0.
- mem_op = MEM_R_EN | MEM_W_EN, taken from the registered values.
- freeze = valid & mem_op & ~mem_ready. This is purely combinational, with no register on the path.
  - If mem_ready=0 while no memory op is held, the stall is ignored and there is no freeze.
- Advance (freeze=0), at the clock edge:
  - valid <= valid_in; ALU_res, Val_Rm, Dest load from their inputs.
  - WB_EN, MEM_R_EN, MEM_W_EN load input & valid_in, so a bubble carries no enables; its data fields still load.
  - If MEM_R_EN_in & MEM_W_EN_in & valid_in: write wins, so MEM_W_EN<=1 and MEM_R_EN<=0; also set protocol_err.
- Hold (freeze=1): every payload and control register keeps its value.
  - The memory stage sees stable address, data and enables for the whole miss.
- Latency: one cycle from input to output when not frozen. When frozen, an input is taken on the first edge after freeze falls.
  - Upstream holds its outputs under freeze, so nothing is lost.
- stall_cnt:
  - On a freeze edge: +1, saturating at 2^CNT_W-1.
  - On an advance edge: cleared to 0.
- total_stalls: +1 on every freeze edge; wraps from 0xFFFFFFFF to 0.
- timeout: set on the edge where stall_cnt goes from TIMEOUT-1 to TIMEOUT. Sticky; cleared only by reset. It does not affect the datapath.
- Back-to-back memory ops: the new op enters on the same edge on which Ready=1 releases the old one. There are no dead cycles.
- Reset mid-stall: all state clears immediately; freeze drops asynchronously with valid.

Test Plan:
- Reset:
  - Drive valid_in=1, MEM_R_EN_in=1, mem_ready=0, rst=0 -> all outputs 0 and freeze=0.
  - Release rst -> next edge captures the inputs; freeze=1.
- Pass-through:
  - mem_ready=1, ALU_res_in=0x400, Val_Rm_in=0xDEADBEEF, Dest_in=5, WB_EN_in=1 -> outputs match one cycle later; stall_cnt=0.
- Load miss:
  - Capture LDR at 0x404, then hold mem_ready=0 for 12 cycles -> freeze=1 throughout, ALU_res stays 0x404, stall_cnt reaches 12, total_stalls=12.
  - Raise mem_ready -> next input captured; stall_cnt=0.
- Bubble and spurious Ready:
  - valid_in=0 with WB_EN_in=1 -> WB_EN=0, valid=0.
  - Then mem_ready=0 with no mem op held -> freeze=0 and the register advances.
- Timeout (TIMEOUT=4, CNT_W=3):
  - Store held with mem_ready=0 for 9 cycles -> timeout=1 after the 4th stall edge; stall_cnt saturates at 7; timeout stays 1 after Ready.
- Illegal op:
  - valid_in=1, MEM_R_EN_in=1, MEM_W_EN_in=1 -> MEM_W_EN=1, MEM_R_EN=0, protocol_err=1 until reset.
